// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/divide unit producing the HI/LO result pair
// Signed MULT/DIV exist only when MULDIV_SIGNED_EN is defined; otherwise op[0] is ignored.
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_value,
  input  logic [WIDTH-1:0] rt_value,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] low_out,
  output logic [WIDTH-1:0] high_out,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               dz_pend_q, dz_pend_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   low_q, low_d;
  logic [WIDTH-1:0]   high_q, high_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;

`ifdef MULDIV_SIGNED_EN
  logic sign_a, sign_b;
  logic neg_pq, neg_rem;
  logic neg_pq_q, neg_pq_d, neg_rem_q, neg_rem_d;

  always_comb begin
    sign_a    = op[0] & rs_value[WIDTH-1];
    sign_b    = op[0] & rt_value[WIDTH-1];
    a_mag     = sign_a ? -rs_value : rs_value;
    b_mag     = sign_b ? -rt_value : rt_value;
    neg_pq    = sign_a ^ sign_b;
    neg_rem   = sign_a;
    neg_pq_d  = (state_q == IDLE && start) ? neg_pq : neg_pq_q;
    neg_rem_d = (state_q == IDLE && start) ? neg_rem : neg_rem_q;
    prod_res  = neg_pq_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    quo_res   = neg_pq_q ? -acc_lo_q : acc_lo_q;
    // remainder follows the dividend's sign (truncating division)
    rem_res   = neg_rem_q ? -acc_hi_q : acc_hi_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_pq_q  <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_pq_q  <= neg_pq_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`else
  logic unused_op_bit;
  assign unused_op_bit = op[0];

  always_comb begin
    a_mag    = rs_value;
    b_mag    = rt_value;
    prod_res = {acc_hi_q, acc_lo_q};
    quo_res  = acc_lo_q;
    rem_res  = acc_hi_q;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    dz_pend_d = dz_pend_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opb_d     = opb_q;
    low_d     = low_q;
    high_d    = high_q;
    done_d    = 1'b0;
    dz_d      = dz_q;

    mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opb_q : {WIDTH{1'b0}})};
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_d     = CW'(WIDTH);
          is_div_d  = op[1];
          dz_pend_d = op[1] & (rt_value == {WIDTH{1'b0}});
          dz_d      = 1'b0;
          acc_hi_d  = {WIDTH{1'b0}};
          acc_lo_d  = a_mag;
          opb_d     = b_mag;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          // restoring step: keep the trial difference only when it did not borrow
          if (!div_diff[WIDTH]) begin
            acc_hi_d = div_diff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = div_shift[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        if (is_div_q) begin
          low_d  = dz_pend_q ? {WIDTH{1'b1}} : quo_res;
          high_d = rem_res;
        end else begin
          low_d  = prod_res[WIDTH-1:0];
          high_d = prod_res[2*WIDTH-1:WIDTH];
        end
        done_d  = 1'b1;
        dz_d    = dz_pend_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      dz_pend_q <= 1'b0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opb_q     <= '0;
      low_q     <= '0;
      high_q    <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      dz_pend_q <= dz_pend_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opb_q     <= opb_d;
      low_q     <= low_d;
      high_q    <= high_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign low_out     = low_q;
  assign high_out    = high_q;
  assign div_by_zero = dz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed-vector bench for muldiv_unit
// Expected values follow the build: signed results only when MULDIV_SIGNED_EN is defined.
module tb_muldiv_unit;
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] rs_value, rt_value;
  logic        busy, done, div_by_zero;
  logic [15:0] low_out, high_out;

  int vectors = 0;
  int miscompares = 0;

  muldiv_unit #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_value(rs_value), .rt_value(rt_value),
    .busy(busy), .done(done), .low_out(low_out), .high_out(high_out),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Drive one request (caller is #1 after an edge with the unit idle) and wait for done.
  task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       output int lat, output logic busy_at_done);
    op = o; rs_value = a; rt_value = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_at_done = 1'b1;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        busy_at_done = busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_value = '0; rt_value = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (low_out !== 16'h0000) begin miscompares++; $display("FAIL reset_low got %h want 0000", low_out); end
    vectors++; if (high_out !== 16'h0000) begin miscompares++; $display("FAIL reset_high got %h want 0000", high_out); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dz got %b want 0", div_by_zero); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_multu();
    int lat; logic bz;
    do_op(OP_MULTU, 16'h00FF, 16'h0101, lat, bz);
    vectors++; if (lat !== 17) begin miscompares++; $display("FAIL multu_latency got %0d want 17", lat); end
    vectors++; if (bz !== 1'b0) begin miscompares++; $display("FAIL multu_busy_with_done got %b want 0", bz); end
    vectors++; if (low_out !== 16'hFFFF) begin miscompares++; $display("FAIL multu_lo got %h want FFFF", low_out); end
    vectors++; if (high_out !== 16'h0000) begin miscompares++; $display("FAIL multu_hi got %h want 0000", high_out); end
    @(posedge clk); #1;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL multu_done_single got %b want 0", done); end
    vectors++; if (low_out !== 16'hFFFF) begin miscompares++; $display("FAIL multu_lo_hold got %h want FFFF", low_out); end
  endtask

  task automatic test_mult();
    int lat; logic bz;
    logic [15:0] e_hi1, e_lo1, e_hi2, e_lo2;
`ifdef MULDIV_SIGNED_EN
    e_hi1 = 16'hFFFF; e_lo1 = 16'hFFFA; e_hi2 = 16'h0000; e_lo2 = 16'h0001;
`else
    e_hi1 = 16'h0002; e_lo1 = 16'hFFFA; e_hi2 = 16'hFFFE; e_lo2 = 16'h0001;
`endif
    do_op(OP_MULT, 16'hFFFE, 16'h0003, lat, bz);
    vectors++; if (lat !== 17) begin miscompares++; $display("FAIL mult_latency got %0d want 17", lat); end
    vectors++; if (high_out !== e_hi1) begin miscompares++; $display("FAIL mult_neg_hi got %h want %h", high_out, e_hi1); end
    vectors++; if (low_out !== e_lo1) begin miscompares++; $display("FAIL mult_neg_lo got %h want %h", low_out, e_lo1); end
    @(posedge clk); #1;
    do_op(OP_MULT, 16'hFFFF, 16'hFFFF, lat, bz);
    vectors++; if (high_out !== e_hi2) begin miscompares++; $display("FAIL mult_negneg_hi got %h want %h", high_out, e_hi2); end
    vectors++; if (low_out !== e_lo2) begin miscompares++; $display("FAIL mult_negneg_lo got %h want %h", low_out, e_lo2); end
    @(posedge clk); #1;
  endtask

  task automatic test_divide();
    int lat; logic bz;
    logic [15:0] e_lo1, e_hi1, e_lo2, e_hi2;
`ifdef MULDIV_SIGNED_EN
    e_lo1 = 16'hFFFD; e_hi1 = 16'hFFFF; e_lo2 = 16'h8000; e_hi2 = 16'h0000;
`else
    e_lo1 = 16'h7FFC; e_hi1 = 16'h0001; e_lo2 = 16'h0000; e_hi2 = 16'h8000;
`endif
    do_op(OP_DIVU, 16'h0064, 16'h0007, lat, bz);
    vectors++; if (lat !== 17) begin miscompares++; $display("FAIL divu_latency got %0d want 17", lat); end
    vectors++; if (low_out !== 16'h000E) begin miscompares++; $display("FAIL divu_lo got %h want 000E", low_out); end
    vectors++; if (high_out !== 16'h0002) begin miscompares++; $display("FAIL divu_hi got %h want 0002", high_out); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL divu_dz got %b want 0", div_by_zero); end
    @(posedge clk); #1;
    do_op(OP_DIV, 16'hFFF9, 16'h0002, lat, bz);
    vectors++; if (low_out !== e_lo1) begin miscompares++; $display("FAIL div_lo got %h want %h", low_out, e_lo1); end
    vectors++; if (high_out !== e_hi1) begin miscompares++; $display("FAIL div_hi got %h want %h", high_out, e_hi1); end
    @(posedge clk); #1;
    do_op(OP_DIV, 16'h8000, 16'hFFFF, lat, bz);
    vectors++; if (low_out !== e_lo2) begin miscompares++; $display("FAIL div_ovf_lo got %h want %h", low_out, e_lo2); end
    vectors++; if (high_out !== e_hi2) begin miscompares++; $display("FAIL div_ovf_hi got %h want %h", high_out, e_hi2); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_by_zero();
    int lat; logic bz;
    do_op(OP_DIVU, 16'h1234, 16'h0000, lat, bz);
    vectors++; if (lat !== 17) begin miscompares++; $display("FAIL dz_latency got %0d want 17", lat); end
    vectors++; if (low_out !== 16'hFFFF) begin miscompares++; $display("FAIL dz_lo got %h want FFFF", low_out); end
    vectors++; if (high_out !== 16'h1234) begin miscompares++; $display("FAIL dz_hi got %h want 1234", high_out); end
    vectors++; if (div_by_zero !== 1'b1) begin miscompares++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
    @(posedge clk); #1;
    vectors++; if (div_by_zero !== 1'b1) begin miscompares++; $display("FAIL dz_sticky got %b want 1", div_by_zero); end
    do_op(OP_DIV, 16'hFFF0, 16'h0000, lat, bz);
    vectors++; if (low_out !== 16'hFFFF) begin miscompares++; $display("FAIL dz_signed_lo got %h want FFFF", low_out); end
    vectors++; if (high_out !== 16'hFFF0) begin miscompares++; $display("FAIL dz_signed_hi got %h want FFF0", high_out); end
    @(posedge clk); #1;
    op = OP_MULTU; rs_value = 16'h0003; rt_value = 16'h0005; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL dz_clear_on_start got %b want 0", div_by_zero); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL dz_next_busy got %b want 1", busy); end
    lat = 0;
    while (lat < 40 && !done) begin @(posedge clk); #1; lat++; end
    vectors++; if (low_out !== 16'h000F) begin miscompares++; $display("FAIL dz_next_lo got %h want 000F", low_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int lat;
    op = OP_DIVU; rs_value = 16'h0064; rt_value = 16'h0007; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (lat == 5) begin
        start = 1'b1; op = OP_MULTU; rs_value = 16'h0010; rt_value = 16'h0002;
      end else begin
        start = 1'b0;
      end
    end
    vectors++; if (lat !== 17) begin miscompares++; $display("FAIL ignore_latency got %0d want 17", lat); end
    vectors++; if (low_out !== 16'h000E) begin miscompares++; $display("FAIL ignore_lo got %h want 000E", low_out); end
    vectors++; if (high_out !== 16'h0002) begin miscompares++; $display("FAIL ignore_hi got %h want 0002", high_out); end
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ignore_idle_after got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat; logic bz;
    do_op(OP_MULTU, 16'h0010, 16'h0010, lat, bz);
    vectors++; if (low_out !== 16'h0100) begin miscompares++; $display("FAIL b2b_first_lo got %h want 0100", low_out); end
    do_op(OP_DIVU, 16'h00FF, 16'h0010, lat, bz);
    vectors++; if (lat !== 17) begin miscompares++; $display("FAIL b2b_latency got %0d want 17", lat); end
    vectors++; if (low_out !== 16'h000F) begin miscompares++; $display("FAIL b2b_lo got %h want 000F", low_out); end
    vectors++; if (high_out !== 16'h000F) begin miscompares++; $display("FAIL b2b_hi got %h want 000F", high_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int lat;
    logic seen_done;
    op = OP_MULTU; rs_value = 16'h0003; rt_value = 16'h0005; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (lat = 1; lat <= 8; lat++) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy); end
    vectors++; if (low_out !== 16'h0000) begin miscompares++; $display("FAIL abort_lo got %h want 0000", low_out); end
    vectors++; if (high_out !== 16'h0000) begin miscompares++; $display("FAIL abort_hi got %h want 0000", high_out); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL abort_dz got %b want 0", div_by_zero); end
    seen_done = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    vectors++; if (seen_done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done got %b want 0", seen_done); end
    vectors++; if (low_out !== 16'h0000) begin miscompares++; $display("FAIL abort_lo_hold got %h want 0000", low_out); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_divide();
    test_div_by_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
